// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks a register-file address range through the spare read port
// and streams each register as a header byte followed by four data bytes, MSB first.
module regfile_dump_reader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic [ADDR_W-1:0] rf_read_address,
   input  logic [DATA_W-1:0] rf_data_read,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_HDR   = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [2:0] HDR_TAG = 3'b101;

   logic [2:0]        state_r,    state_s;
   logic [ADDR_W-1:0] cur_addr_r, cur_addr_s;
   logic [ADDR_W-1:0] last_r,     last_s;
   logic [DATA_W-1:0] shadow_r,   shadow_s;
   logic [1:0]        byte_idx_r, byte_idx_s;

   logic              out_valid_r, out_valid_s;
   logic [BYTE_W-1:0] out_data_r,  out_data_s;
   logic              out_last_r,  out_last_s;
   logic              busy_r,      busy_s;
   logic              done_r,      done_s;
   logic              handshake_s;

   // Next-state logic for the dump sequencer
   always_comb begin
      state_s     = state_r;
      cur_addr_s  = cur_addr_r;
      last_s      = last_r;
      shadow_s    = shadow_r;
      byte_idx_s  = byte_idx_r;
      handshake_s = out_valid_r & out_ready;
      case (state_r)
         ST_IDLE: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else if (start) begin
               cur_addr_s = first_addr;
               last_s     = last_addr;
               if (first_addr > last_addr) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_FETCH;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else begin
               shadow_s = rf_data_read;
               state_s  = ST_HDR;
            end
         end
         ST_HDR: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else if (handshake_s) begin
               state_s    = ST_DATA;
               byte_idx_s = 2'd0;
            end else begin
               state_s = ST_HDR;
            end
         end
         ST_DATA: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else if (handshake_s) begin
               if (byte_idx_r != 2'd3) begin
                  byte_idx_s = byte_idx_r + 2'd1;
               end else if (cur_addr_r == last_r) begin
                  state_s = ST_DONE;
               end else begin
                  // stop condition above guarantees no wrap past the top address
                  cur_addr_s = cur_addr_r + 1'b1;
                  state_s    = ST_FETCH;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output values for the upcoming cycle, derived from the next state so they can be registered
   always_comb begin
      out_valid_s = (state_s == ST_HDR) || (state_s == ST_DATA);
      out_last_s  = (state_s == ST_DATA) && (byte_idx_s == 2'd3) && (cur_addr_s == last_s);
      busy_s      = (state_s != ST_IDLE);
      done_s      = (state_s == ST_DONE);
      out_data_s  = {BYTE_W{1'b0}};
      if (state_s == ST_HDR) begin
         out_data_s = {HDR_TAG, cur_addr_s};
      end else if (state_s == ST_DATA) begin
         case (byte_idx_s)
            2'd0:    out_data_s = shadow_s[DATA_W-1            -: BYTE_W];
            2'd1:    out_data_s = shadow_s[DATA_W-1-BYTE_W     -: BYTE_W];
            2'd2:    out_data_s = shadow_s[DATA_W-1-2*BYTE_W   -: BYTE_W];
            2'd3:    out_data_s = shadow_s[DATA_W-1-3*BYTE_W   -: BYTE_W];
            default: out_data_s = {BYTE_W{1'b0}};
         endcase
      end else begin
         out_data_s = {BYTE_W{1'b0}};
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         cur_addr_r  <= {ADDR_W{1'b0}};
         last_r      <= {ADDR_W{1'b0}};
         shadow_r    <= {DATA_W{1'b0}};
         byte_idx_r  <= 2'd0;
         out_valid_r <= 1'b0;
         out_data_r  <= {BYTE_W{1'b0}};
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         cur_addr_r  <= cur_addr_s;
         last_r      <= last_s;
         shadow_r    <= shadow_s;
         byte_idx_r  <= byte_idx_s;
         out_valid_r <= out_valid_s;
         out_data_r  <= out_data_s;
         out_last_r  <= out_last_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
      end
   end

   assign rf_read_address = cur_addr_r;
   assign out_valid       = out_valid_r;
   assign out_data        = out_data_r;
   assign out_last        = out_last_r;
   assign busy            = busy_r;
   assign done            = done_r;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader: a register-file array drives the read port and
// every dump is compared byte-by-byte against a frame list built from the register contents.
module tb_regfile_dump_reader;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [4:0]  first_addr;
   logic [4:0]  last_addr;
   logic [4:0]  rf_read_address;
   logic [31:0] rf_data_read;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [31:0] regs [0:31];
   int          n_checks = 0;
   int          n_pass   = 0;

   regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .BYTE_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .first_addr(first_addr), .last_addr(last_addr),
      .rf_read_address(rf_read_address), .rf_data_read(rf_data_read),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // x0 is hardwired to zero, like the CPU register file
   assign rf_data_read = (rf_read_address == 5'd0) ? 32'd0 : regs[rf_read_address];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [31:0] rd(input int a);
      return (a == 0) ? 32'd0 : regs[a];
   endfunction

   // One dump: pct = chance of out_ready per cycle, abort_pos = byte index to abort at (-1 none),
   // mid = cycle at which a stray start is pulsed while busy (-1 none).
   task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int pct,
                           input int abort_pos, input int mid);
      logic [7:0]  q[$];
      logic [31:0] w;
      logic [4:0]  a5;
      logic [7:0]  pd, d;
      logic        pl, v, la, dn, b;
      int          got;
      bit          fin, stalled, aborted, rdy;
      q.delete();
      if (f <= l) begin
         for (int a = int'(f); a <= int'(l); a++) begin
            a5 = a[4:0];
            w  = rd(a);
            q.push_back({3'b101, a5});
            q.push_back(w[31:24]);
            q.push_back(w[23:16]);
            q.push_back(w[15:8]);
            q.push_back(w[7:0]);
         end
      end
      got = 0; fin = 0; stalled = 0; aborted = 0; pd = 8'd0; pl = 1'b0;
      @(negedge clk);
      first_addr = f; last_addr = l; start = 1'b1; abort = 1'b0;
      for (int k = 1; k <= 400 && !fin; k++) begin
         @(negedge clk);
         start = (k == mid);
         if (k == mid) begin
            first_addr = 5'd0;
            last_addr  = 5'd31;
         end
         abort = 1'b0;
         #1;
         v = out_valid; d = out_data; la = out_last; dn = done; b = busy;
         if (aborted) begin
            check("abort_valid", {31'd0, v}, 32'd0);
            check("abort_busy", {31'd0, b}, 32'd0);
            check("abort_done", {31'd0, dn}, 32'd0);
            fin = 1;
         end else begin
            if (stalled) begin
               check("hold_valid", {31'd0, v}, 32'd1);
               check("hold_data", {24'd0, d}, {24'd0, pd});
               check("hold_last", {31'd0, la}, {31'd0, pl});
            end
            stalled = 0;
            if (dn) begin
               check("done_count", got, q.size());
               check("done_busy", {31'd0, b}, 32'd1);
               check("done_valid", {31'd0, v}, 32'd0);
               if (pct == 100) check("done_cycle", k, 6 * (q.size() / 5) + 1);
               fin = 1;
            end else if (v) begin
               check("byte_expected", {31'd0, got < q.size()}, 32'd1);
               if (got == abort_pos) begin
                  abort = 1'b1; out_ready = 1'b0; aborted = 1;
               end else begin
                  rdy = ($urandom_range(99) < pct);
                  out_ready = rdy;
                  if (rdy && got < q.size()) begin
                     check("data", {24'd0, d}, {24'd0, q[got]});
                     check("last", {31'd0, la}, {31'd0, got == q.size() - 1});
                     if (pct == 100) check("byte_cycle", k, 2 + 6 * (got / 5) + (got % 5));
                     got++;
                  end else if (!rdy) begin
                     stalled = 1; pd = d; pl = la;
                  end
               end
            end else begin
               out_ready = 1'($urandom_range(1));
            end
         end
      end
      check("finished", {31'd0, fin}, 32'd1);
      start = 1'b0; abort = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      logic [4:0] rf, rl, tmp;
      int         pct;
      rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      first_addr = 5'd0; last_addr = 5'd0;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      repeat (3) @(negedge clk);
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_addr", {27'd0, rf_read_address}, 32'd0);
      check("rst_data", {24'd0, out_data}, 32'd0);
      rst = 1'b1;

      regs[5] = 32'hDEADBEEF;
      run_dump(5'd5, 5'd5, 100, -1, -1);
      run_dump(5'd5, 5'd5, 50, -1, -1);

      for (int i = 0; i < 32; i++) regs[i] = i * 32'h01010101;
      run_dump(5'd0, 5'd31, 100, -1, 8);

      run_dump(5'd7, 5'd3, 100, -1, -1);

      // start and abort together in IDLE: abort wins
      @(negedge clk); start = 1'b1; abort = 1'b1; first_addr = 5'd1; last_addr = 5'd2;
      @(negedge clk); start = 1'b0; abort = 1'b0; #1;
      check("start_abort_busy", {31'd0, busy}, 32'd0);
      check("start_abort_valid", {31'd0, out_valid}, 32'd0);

      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      run_dump(5'd2, 5'd6, 70, 13, -1);
      run_dump(5'd9, 5'd9, 100, -1, -1);
      run_dump(5'd29, 5'd31, 60, -1, -1);

      // reset held mid-stream
      @(negedge clk); first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_addr", {27'd0, rf_read_address}, 32'd0);
      rst = 1'b1; out_ready = 1'b0;

      repeat (15) begin
         for (int i = 0; i < 32; i++) regs[i] = $urandom;
         rf = 5'($urandom_range(31));
         rl = 5'($urandom_range(31));
         if (rf > rl && $urandom_range(3) != 0) begin
            tmp = rf; rf = rl; rl = tmp;
         end
         if (int'(rl) - int'(rf) > 8) rl = rf + 5'd8;
         pct = ($urandom_range(1) == 1) ? 100 : int'($urandom_range(99, 20));
         run_dump(rf, rl, pct, -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
